// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// Ports: clk, rst, opcode, branch_taken, mem_ready in; datapath selects/enables, illegal, mem_err, state, instret out.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic             illegal,
  output logic             mem_err,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             wait_last;

  assign wait_last = (wait_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          // PC <= PC + 4 while the instruction lands in IR
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          state_d   = S_DECODE;
        end else if (wait_last) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Speculatively form old_pc + imm into ALUOut
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        unique case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LD, OP_ST: state_d = S_MEM_ADDR;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (wait_last) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (wait_last) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = branch_taken;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = 2'b01;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter restarts on every state change, completion or abort
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || mem_ready || mem_err) begin
      wait_d = '0;
    end else if (mem_req) begin
      wait_d = wait_q + WC_W'(1);
    end
  end

  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule
